// File: rtl/hexseg_pkg.sv
// Shared constants and types for the hex seven-segment scan decoder.
package hexseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} pattern per hex value; the index is the value.
    localparam logic [15:0][6:0] SEG_CODE = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    typedef struct packed {
        logic       hit;
        logic       blank;
        logic [3:0] value;
    } seg_pat_t;

endpackage

// File: rtl/hexseg_pattern_dec.sv
// Combinational segment-pattern classifier: table hit with its hex value, blank, or neither.
module hexseg_pattern_dec
    import hexseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output seg_pat_t   pat_o
);

    always_comb begin
        pat_o       = '0;
        pat_o.blank = (seg_i == SEG_BLANK);
        for (int v = 0; v < 16; v++) begin
            if (seg_i == SEG_CODE[v]) begin
                pat_o.hit   = 1'b1;
                pat_o.value = 4'(v);
            end
        end
    end

endmodule

// File: rtl/hexseg_scan_decoder.sv
// Reconstructs four hex digits from a multiplexed active-low seven-segment scan.
// Optional HEXSEG_TIMEOUT_EN adds per-digit ageing that drops valid after TIMEOUT strobes without refresh.
module hexseg_scan_decoder
    import hexseg_pkg::*;
#(
    parameter int SAMPLE_DIV = 16,
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] valid,
    output logic       upd,
    output logic [1:0] upd_idx,
    output logic       err_pat,
    output logic       err_an
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STABLE_CNT - 1);

    logic [DIV_W-1:0]                 div_q, div_d;
    logic [3:0]                       an_q;
    logic [6:0]                       seg_q;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]       dig_q, dig_d;
    logic [NUM_DIGITS-1:0]            valid_q, valid_d, expire;
    logic                             upd_q, upd_d, err_pat_q, err_pat_d, err_an_q, err_an_d;
    logic [1:0]                       upd_idx_q, upd_idx_d, idx;
    logic                             strobe, same, dark, multi, accept;
    logic [3:0]                       low;
    seg_pat_t                         pat;

    hexseg_pattern_dec u_dec (
        .seg_i (seg_q),
        .pat_o (pat)
    );

    assign strobe = (div_q == DIV_LAST);
    assign div_d  = strobe ? '0 : div_q + DIV_W'(1);
    assign low    = ~an;
    assign dark   = (low == 4'd0);
    assign multi  = ((low & (low - 4'd1)) != 4'd0);
    assign same   = ({an, seg} == {an_q, seg_q});

    // Stable-run filter; accept fires once, on the strobe that completes the run.
    always_comb begin
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (strobe) begin
            if (dark || multi) begin
                cnt_d = '0;
            end else if (same) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                accept = (cnt_q == CNT_PRE);
            end else begin
                cnt_d = CNT_W'(1);
            end
        end
    end

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) idx = 2'(i);
        end
    end

`ifdef HEXSEG_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

    logic [NUM_DIGITS-1:0][AGE_W-1:0] age_q, age_d;
    logic                             acc_ok;

    assign acc_ok = accept && (pat.hit || pat.blank);

    always_comb begin
        age_d  = age_q;
        expire = '0;
        if (strobe) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (acc_ok && (idx == 2'(i))) begin
                    age_d[i] = '0;
                end else if (age_q[i] != AGE_MAX) begin
                    age_d[i]  = age_q[i] + AGE_W'(1);
                    expire[i] = (age_q[i] == AGE_MAX - AGE_W'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire         = '0;
`endif

    // Accepts are applied after ageing so a same-cycle refresh keeps the digit valid.
    always_comb begin
        dig_d     = dig_q;
        valid_d   = valid_q & ~expire;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        err_pat_d = 1'b0;
        err_an_d  = strobe && multi;
        if (accept) begin
            if (pat.hit) begin
                dig_d[idx]   = pat.value;
                valid_d[idx] = 1'b1;
                upd_d        = 1'b1;
                upd_idx_d    = idx;
            end else if (pat.blank) begin
                valid_d[idx] = 1'b0;
                upd_d        = 1'b1;
                upd_idx_d    = idx;
            end else begin
                err_pat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            an_q      <= 4'hF;
            seg_q     <= SEG_BLANK;
            cnt_q     <= '0;
            dig_q     <= '0;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= 2'd0;
            err_pat_q <= 1'b0;
            err_an_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            if (strobe) begin
                an_q  <= an;
                seg_q <= seg;
            end
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_pat_q <= err_pat_d;
            err_an_q  <= err_an_d;
        end
    end

    assign d0      = dig_q[0];
    assign d1      = dig_q[1];
    assign d2      = dig_q[2];
    assign d3      = dig_q[3];
    assign valid   = valid_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign err_pat = err_pat_q;
    assign err_an  = err_an_q;

endmodule

// File: tb/tb_hexseg_scan_decoder.sv
// Self-checking bench for hexseg_scan_decoder: table vectors, corner sequences and random traffic vs a run-length model.
module tb_hexseg_scan_decoder;

    localparam int SD = 4;
    localparam int SC = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] d0, d1, d2, d3, valid;
    logic       upd, err_pat, err_an;
    logic [1:0] upd_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_seen, errp_seen, erra_seen;

    hexseg_scan_decoder #(.SAMPLE_DIV(SD), .STABLE_CNT(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .valid(valid),
        .upd(upd), .upd_idx(upd_idx), .err_pat(err_pat), .err_an(err_an)
    );

    always #5 clk = ~clk;

    logic [6:0] CODES [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference model state: run length of identical samples, decoded digits, pulses.
    int         edge_n;
    logic [3:0] m_prev_an;
    logic [6:0] m_prev_seg;
    int         m_run;
    logic [3:0] m_d [4];
    logic [3:0] m_valid;
    logic       m_upd, m_errp, m_erra;
    logic [1:0] m_idx;
    int         m_age [4];

    function automatic int seg2val(logic [6:0] s);
        for (int v = 0; v < 16; v++) if (s == CODES[v]) return v;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        edge_n = 0; m_prev_an = 4'hF; m_prev_seg = 7'h7F; m_run = 0;
        for (int i = 0; i < 4; i++) begin m_d[i] = 4'h0; m_age[i] = 0; end
        m_valid = 4'h0; m_upd = 1'b0; m_errp = 1'b0; m_erra = 1'b0; m_idx = 2'd0;
    endtask

    task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
        int zeros, dig, val, acc_dig;
        m_upd = 1'b0; m_errp = 1'b0; m_erra = 1'b0;
        edge_n++;
        if (edge_n % SD != 0) return;
        zeros = 0; dig = 0; acc_dig = -1;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; dig = i; end
        if (zeros == 0) m_run = 0;
        else if (zeros > 1) begin m_run = 0; m_erra = 1'b1; end
        else if (a == m_prev_an && s == m_prev_seg) m_run++;
        else m_run = 1;
        m_prev_an = a; m_prev_seg = s;
        val = seg2val(s);
        if (m_run == SC && (val >= 0 || s == 7'h7F)) acc_dig = dig;
`ifdef HEXSEG_TIMEOUT_EN
        for (int j = 0; j < 4; j++) begin
            if (j == acc_dig) m_age[j] = 0;
            else if (m_age[j] < TO) begin
                m_age[j]++;
                if (m_age[j] == TO) m_valid[j] = 1'b0;
            end
        end
`endif
        if (m_run == SC) begin
            if (val >= 0) begin
                m_d[dig] = 4'(val); m_valid[dig] = 1'b1; m_upd = 1'b1; m_idx = 2'(dig);
            end else if (s == 7'h7F) begin
                m_valid[dig] = 1'b0; m_upd = 1'b1; m_idx = 2'(dig);
            end else begin
                m_errp = 1'b1;
            end
        end
    endtask

    task automatic check_cycle();
        logic [24:0] act, exp;
        act = {d3, d2, d1, d0, valid, upd, upd_idx, err_pat, err_an};
        exp = {m_d[3], m_d[2], m_d[1], m_d[0], m_valid, m_upd, m_idx, m_errp, m_erra};
        chk("cycle", 32'(act), 32'(exp));
        if (upd)     upd_seen++;
        if (err_pat) errp_seen++;
        if (err_an)  erra_seen++;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge(an, seg);
        #1;
        check_cycle();
    endtask

    task automatic clr_counts();
        upd_seen = 0; errp_seen = 0; erra_seen = 0;
    endtask

    // Hold a value for n strobe edges; with junk, non-strobe cycles carry random noise.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n, input bit junk);
        int got = 0;
        while (got < n) begin
            if (junk && ((edge_n + 1) % SD != 0)) begin
                an = 4'($urandom); seg = 7'($urandom);
            end else begin
                an = a; seg = s;
            end
            step();
            if (edge_n % SD == 0) got++;
        end
    endtask

    function automatic logic [3:0] dig_out(int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         idx;
        logic [3:0] val;
        logic [3:0] vmask;
        int         n_upd;
        int         n_errp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{4'b1110, 7'h12, 0, 4'h2, 4'b0001, 1, 0};
        tbl[1] = '{4'b1110, 7'h06, 0, 4'h3, 4'b0001, 1, 0};
        tbl[2] = '{4'b1101, 7'h0F, 1, 4'h7, 4'b0011, 1, 0};
        tbl[3] = '{4'b1011, 7'h08, 2, 4'hA, 4'b0111, 1, 0};
        tbl[4] = '{4'b0111, 7'h38, 3, 4'hF, 4'b1111, 1, 0};
        tbl[5] = '{4'b1101, 7'h7F, 1, 4'h7, 4'b1101, 1, 0};
        tbl[6] = '{4'b1011, 7'h55, 2, 4'hA, 4'b1101, 0, 1};

        rst = 1'b1; an = 4'hF; seg = 7'h7F;
        model_reset(); clr_counts();
        step(); step();
        chk("reset_outputs", 32'({d3, d2, d1, d0, valid, upd, upd_idx, err_pat, err_an}), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            clr_counts();
            hold(tbl[k].an, tbl[k].seg, SC + 1, 1'b0);
            chk($sformatf("tbl%0d_digit", k), 32'(dig_out(tbl[k].idx)), 32'(tbl[k].val));
            chk($sformatf("tbl%0d_upd", k), 32'(upd_seen), 32'(tbl[k].n_upd));
            chk($sformatf("tbl%0d_errpat", k), 32'(errp_seen), 32'(tbl[k].n_errp));
            if (tbl[k].n_upd > 0) chk($sformatf("tbl%0d_idx", k), 32'(upd_idx), 32'(tbl[k].idx));
`ifndef HEXSEG_TIMEOUT_EN
            chk($sformatf("tbl%0d_valid", k), 32'(valid), 32'(tbl[k].vmask));
`endif
        end

        // One-strobe glitch restarts the run; accept needs four clean strobes after it.
        hold(4'hF, 7'h7F, 1, 1'b0);
        clr_counts();
        hold(4'b1110, 7'h06, 2, 1'b0);
        hold(4'b1110, 7'h07, 1, 1'b0);
        hold(4'b1110, 7'h06, 3, 1'b0);
        chk("glitch_no_early_upd", 32'(upd_seen), 32'd0);
        hold(4'b1110, 7'h06, 1, 1'b0);
        chk("glitch_upd_after_4", 32'(upd_seen), 32'd1);
        chk("glitch_d0", 32'(d0), 32'h3);

        clr_counts();
        hold(4'b1010, 7'h12, 3, 1'b0);
        chk("multi_an_err", 32'(erra_seen), 32'd3);
        chk("multi_an_no_upd", 32'(upd_seen), 32'd0);

        // Ageing: refresh digit 1 once, then scan only digit 0.
        hold(4'hF, 7'h7F, 1, 1'b0);
        hold(4'b1101, 7'h4F, SC, 1'b0);
        chk("age_accept_d1", 32'({d1, valid[1]}), 32'({4'h1, 1'b1}));
        hold(4'b1110, 7'h01, 7, 1'b0);
        chk("age_valid1_before", 32'(valid[1]), 32'd1);
        hold(4'b1110, 7'h01, 1, 1'b0);
`ifdef HEXSEG_TIMEOUT_EN
        chk("age_valid1_dropped", 32'(valid[1]), 32'd0);
`else
        chk("age_valid1_kept", 32'(valid[1]), 32'd1);
`endif
        chk("age_d1_kept", 32'(d1), 32'h1);

        for (int r = 0; r < 80; r++) begin
            int         sel;
            logic [3:0] a;
            logic [6:0] s;
            sel = $urandom_range(0, 9);
            if (sel == 4) a = 4'hF;
            else if (sel == 5) begin
                a = 4'($urandom);
                if (a == 4'hF || a == 4'hE || a == 4'hD || a == 4'hB || a == 4'h7) a = 4'b0101;
            end else begin
                a = 4'hF;
                a[$urandom_range(0, 3)] = 1'b0;
            end
            sel = $urandom_range(0, 19);
            if (sel < 14) s = CODES[$urandom_range(0, 15)];
            else if (sel < 17) s = 7'h7F;
            else s = 7'($urandom);
            hold(a, s, $urandom_range(1, 6), 1'b1);
        end

        // Async reset mid-traffic, then first-accept latency from release.
        hold(4'b1110, 7'h4F, SC + 1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", 32'({d3, d2, d1, d0, valid, upd, upd_idx, err_pat, err_an}), 32'd0);
        model_reset();
        step(); step();
        rst = 1'b0; an = 4'b1110; seg = 7'h01;
        clr_counts();
        for (int c = 0; c < SC * SD - 1; c++) step();
        chk("post_rst_no_early_upd", 32'(upd_seen), 32'd0);
        step();
        chk("post_rst_first_upd", 32'({upd, upd_idx, valid[0], d0}), 32'({1'b1, 2'd0, 1'b1, 4'h0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
